// File: rtl/fetch_seq_pkg.sv
// ============================================================================
// Module   : fetch_seq_pkg
// Brief    : Shared types for the fetch sequencer: FSM state and redirect kind.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_seq_pkg;

  localparam int FS_ADDR_W     = 8;
  localparam int FS_RESET_ADDR = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } fs_state_t;

  typedef enum logic [2:0] {
    RD_SEQ  = 3'd0,
    RD_BR   = 3'd1,
    RD_JMP  = 3'd2,
    RD_CALL = 3'd3,
    RD_RET  = 3'd4,
    RD_HALT = 3'd5,
    RD_HOLD = 3'd6
  } fs_redirect_t;

  // Lower-priority controls are dropped entirely once a higher one is seen.
  function automatic fs_redirect_t fs_decode_redirect(
    input logic halt,
    input logic stall,
    input logic ret_en,
    input logic call_en,
    input logic jmp_en,
    input logic br_taken
  );
    if (halt)          return RD_HALT;
    else if (stall)    return RD_HOLD;
    else if (ret_en)   return RD_RET;
    else if (call_en)  return RD_CALL;
    else if (jmp_en)   return RD_JMP;
    else if (br_taken) return RD_BR;
    else               return RD_SEQ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ras.sv
// ============================================================================
// Module   : fetch_ras
// Brief    : Circular return-address stack; a push when full overwrites the
//            oldest entry and raises overflow, a pop when empty raises underflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ras
  import fetch_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FS_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr names the next free slot; DEPTH is a power of two so it wraps freely.
  assign w_top_idx   = r_ptr - PTR_W'(1);
  assign o_top       = r_mem[w_top_idx];
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_overflow  = i_push & ~i_pop & o_full;
  assign o_underflow = i_pop & o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_pop) begin
      if (!o_empty) begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - CNT_W'(1);
      end
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (!o_full) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC / instruction-fetch controller with return-address stack and
//            halt/resume. FETCH_SEQUENCER_PERF_EN enables the retired counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W     = FS_ADDR_W,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = FS_RESET_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              halt,
  input  logic              resume,
  output logic              ras_err,
  output logic [1:0]        state_o,
  output logic [15:0]       perf_retired
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_ADDR);

  fs_state_t         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic              r_ras_err;

  fs_redirect_t      w_kind;
  logic              w_in_exec;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_br;
  logic              w_ras_push;
  logic              w_ras_pop;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_unused_ras_full;
  logic              w_ras_overflow;
  logic              w_ras_underflow;

  assign w_kind     = fs_decode_redirect(halt, stall, ret_en, call_en, jmp_en, br_taken);
  assign w_in_exec  = (r_state == ST_EXEC);
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_pc_br    = r_pc + br_offset;
  assign w_ras_push = w_in_exec && (w_kind == RD_CALL);
  assign w_ras_pop  = w_in_exec && (w_kind == RD_RET);

  fetch_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_ras_push),
    .i_pop       (w_ras_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_unused_ras_full),
    .o_overflow  (w_ras_overflow),
    .o_underflow (w_ras_underflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= C_RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_ras_err     <= 1'b0;
    end else begin
      if (w_ras_overflow || w_ras_underflow) begin
        r_ras_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_state       <= ST_EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        ST_EXEC: begin
          case (w_kind)
            RD_HOLD: ;
            RD_HALT: begin
              r_pc          <= w_pc_inc;
              r_state       <= ST_HALTED;
              r_instr_valid <= 1'b0;
            end
            default: begin
              r_state       <= ST_FETCH;
              r_instr_valid <= 1'b0;
              r_imem_req    <= 1'b1;
              case (w_kind)
                RD_RET:         r_pc <= w_ras_empty ? w_pc_inc : w_ras_top;
                RD_CALL, RD_JMP: r_pc <= jmp_target;
                RD_BR:          r_pc <= w_pc_br;
                default:        r_pc <= w_pc_inc;
              endcase
            end
          endcase
        end
        ST_HALTED: begin
          if (resume) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_addr  = r_pc;
  assign ras_err     = r_ras_err;
  assign state_o     = r_state;

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] r_perf;
  logic        w_retire;

  assign w_retire = w_in_exec && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_retire && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_retired = r_perf;
`else
  assign perf_retired = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Scoreboard bench for fetch_sequencer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef FETCH_SEQUENCER_PERF_EN
  localparam logic [15:0] PERF_MASK = 16'hFFFF;
`else
  localparam logic [15:0] PERF_MASK = 16'h0000;
`endif

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic          instr_valid;
  logic [AW-1:0] instr_addr;
  logic          stall;
  logic          br_taken;
  logic [AW-1:0] br_offset;
  logic          jmp_en;
  logic          call_en;
  logic          ret_en;
  logic [AW-1:0] jmp_target;
  logic          halt;
  logic          resume;
  logic          ras_err;
  logic [1:0]    state_o;
  logic [15:0]   perf_retired;

  fetch_sequencer #(
    .ADDR_W     (AW),
    .RAS_DEPTH  (DEPTH),
    .RESET_ADDR (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .instr_addr   (instr_addr),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .jmp_en       (jmp_en),
    .call_en      (call_en),
    .ret_en       (ret_en),
    .jmp_target   (jmp_target),
    .halt         (halt),
    .resume       (resume),
    .ras_err      (ras_err),
    .state_o      (state_o),
    .perf_retired (perf_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        err;
    logic [15:0] ret;
  } exec_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fetch_q [$];
  exec_exp_t   exec_q [$];

  // Reference model: architectural PC, call stack as a bounded queue.
  logic [7:0]  m_pc;
  logic [7:0]  m_stack [$];
  logic        m_err;
  logic [15:0] m_ret;
  bit          m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_pc     = 8'h00;
    m_stack.delete();
    m_err    = 1'b0;
    m_ret    = 16'd0;
    m_halted = 1'b0;
  endtask

  task automatic model_exec(input bit h, s, r, c, j, b, input logic [7:0] off, tgt);
    if (!s && m_ret != 16'hFFFF) m_ret++;
    if (h) begin
      m_pc     = m_pc + 8'd1;
      m_halted = 1'b1;
    end else if (s) begin
      m_pc = m_pc;
    end else if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = m_pc + 8'd1;
        m_err = 1'b1;
      end
    end else if (c) begin
      if (m_stack.size() == DEPTH) begin
        void'(m_stack.pop_front());
        m_err = 1'b1;
      end
      m_stack.push_back(m_pc + 8'd1);
      m_pc = tgt;
    end else if (j) begin
      m_pc = tgt;
    end else if (b) begin
      m_pc = m_pc + off;
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic clear_ctrl();
    stall = 0; br_taken = 0; jmp_en = 0; call_en = 0; ret_en = 0;
    halt = 0; resume = 0; imem_ack = 0;
    br_offset = '0; jmp_target = '0;
  endtask

  // Drives one EXEC cycle: resumes if halted, serves fetches, then applies controls.
  task automatic exec_one(input bit h, s, r, c, j, b, input logic [7:0] off, tgt, input bit rnd);
    int budget;
    if (m_halted) begin
      repeat ($urandom_range(0, 2)) begin
        imem_ack = 1'($urandom_range(0, 1));
        step();
      end
      resume   = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      step();
      resume   = 1'b0;
      m_halted = 1'b0;
    end
    budget = 0;
    while (!instr_valid) begin
      if (budget >= 40) begin
        checks++;
        errors++;
        $display("FAIL exec_timeout: no instr_valid after %0d cycles, expected pc 0x%0h", budget, m_pc);
        clear_ctrl();
        return;
      end
      imem_ack = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (imem_req && imem_ack) fetch_q.push_back(m_pc);
      step();
      budget++;
    end
    halt = h; stall = s; ret_en = r; call_en = c; jmp_en = j; br_taken = b;
    br_offset = off; jmp_target = tgt;
    imem_ack = 1'($urandom_range(0, 1));
    exec_q.push_back('{addr: m_pc, err: m_err, ret: m_ret});
    model_exec(h, s, r, c, j, b, off, tgt);
    step();
    clear_ctrl();
  endtask

  task automatic plain(input bit rnd);
    exec_one(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, rnd);
  endtask

  // Monitor: compares presented fetches/instructions and per-cycle sequencing rules.
  initial begin
    bit p_hs, p_redirect, p_stall, p_halt, p_resume, in_halt;
    exec_exp_t e;
    p_hs = 0; p_redirect = 0; p_stall = 0; p_halt = 0; p_resume = 0; in_halt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_hs = 0; p_redirect = 0; p_stall = 0; p_halt = 0; p_resume = 0; in_halt = 0;
        continue;
      end
      if (p_hs)       chk("ack_to_exec", {instr_valid, imem_req, state_o}, {1'b1, 1'b0, 2'd2});
      if (p_redirect) chk("exec_to_fetch", {instr_valid, imem_req, state_o}, {1'b0, 1'b1, 2'd1});
      if (p_stall)    chk("stall_holds", {instr_valid, state_o}, {1'b1, 2'd2});
      if (p_resume)   chk("resume_to_fetch", {imem_req, state_o}, {1'b1, 2'd1});
      if (p_halt) begin
        chk("halt_state", state_o, 2'd3);
        in_halt = 1;
      end
      p_hs = 0; p_redirect = 0; p_stall = 0; p_halt = 0; p_resume = 0;
      if (in_halt) begin
        chk("halted_quiet", {imem_req, instr_valid}, 2'b00);
        if (resume) begin
          p_resume = 1;
          in_halt  = 0;
        end
      end
      if (imem_req && imem_ack) begin
        if (fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected: got addr 0x%0h, expected no fetch", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, fetch_q.pop_front());
        end
        p_hs = 1;
      end
      if (instr_valid) begin
        if (exec_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_unexpected: got instr_addr 0x%0h, expected no instruction", instr_addr);
        end else begin
          e = exec_q.pop_front();
          chk("instr_addr", instr_addr, e.addr);
          chk("ras_err", ras_err, e.err);
          chk("perf_retired", perf_retired, e.ret & PERF_MASK);
        end
        if (halt)       p_halt = 1;
        else if (stall) p_stall = 1;
        else            p_redirect = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_ctrl();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    model_reset();
    chk("rst_state", state_o, 2'd0);
    chk("rst_req_valid", {imem_req, instr_valid}, 2'b00);
    chk("rst_pc", instr_addr, 8'h00);
    chk("rst_ras_err", ras_err, 1'b0);
    chk("rst_perf", perf_retired, 16'd0);

    // Sequential fetch with zero-wait memory
    repeat (3) plain(0);

    // Negative branch and PC wrap
    exec_one(0, 0, 0, 0, 1, 0, 8'h00, 8'h10, 0);
    exec_one(0, 0, 0, 0, 0, 1, 8'hF8, 8'h00, 0);
    exec_one(0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0);
    plain(0);
    plain(0);

    // Call / return pair
    exec_one(0, 0, 0, 0, 1, 0, 8'h00, 8'h20, 0);
    exec_one(0, 0, 0, 1, 0, 0, 8'h00, 8'h80, 0);
    exec_one(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    plain(0);

    // Simultaneous call+ret: only the return is performed
    exec_one(0, 0, 0, 1, 0, 0, 8'h00, 8'h44, 0);
    exec_one(0, 0, 1, 1, 0, 0, 8'h00, 8'h99, 0);
    plain(0);

    // Five nested calls overflow a 4-deep stack, then five returns
    for (int k = 0; k < 5; k++) exec_one(0, 0, 0, 1, 0, 0, 8'h00, 8'(8'h30 + 8'(k * 16)), 0);
    for (int k = 0; k < 5; k++) exec_one(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0);
    plain(0);

    // Stall holds EXEC and masks the jump until released
    repeat (3) exec_one(0, 1, 0, 0, 1, 0, 8'h00, 8'hA0, 0);
    exec_one(0, 0, 0, 0, 1, 0, 8'h00, 8'hA0, 0);

    // Halt at 0x05 then resume
    exec_one(0, 0, 0, 0, 1, 0, 8'h00, 8'h05, 0);
    exec_one(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    plain(0);

    // Randomized controls and memory latency
    for (int i = 0; i < 300; i++) begin
      bit h, s, r, c, j, b;
      h = ($urandom_range(0, 99) < 5);
      s = ($urandom_range(0, 99) < 12);
      r = ($urandom_range(0, 99) < 25);
      c = ($urandom_range(0, 99) < 25);
      j = ($urandom_range(0, 99) < 15);
      b = ($urandom_range(0, 99) < 30);
      exec_one(h, s, r, c, j, b, 8'($urandom), 8'($urandom), 1'b1);
    end

    // Reset while FETCH waits for imem_ack
    plain(1);
    chk("pre_reset_req", imem_req, 1'b1);
    imem_ack = 1'b0;
    step();
    chk("fetch_waits", state_o, 2'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("midrst_state", state_o, 2'd0);
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_pc", instr_addr, 8'h00);
    chk("midrst_err", ras_err, 1'b0);
    chk("midrst_perf", perf_retired, 16'd0);
    repeat (3) plain(1);
    chk("perf_after3", perf_retired, 16'd3 & PERF_MASK);
    plain(1);

    step();
    step();
    chk("fetch_q_drained", fetch_q.size(), 0);
    chk("exec_q_drained", exec_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
